// File: rtl/tdm_demux4.sv
// 1-to-4 TDM demultiplexer: manual channel select or frame-aligned rotating slot (auto mode).
// Optional build macro TDM_DEMUX_FRAME_CNT_EN adds an 8-bit completed-frame counter output.
module tdm_demux4 #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned HOLD  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   x,
  input  logic               in_valid,
  input  logic [1:0]         sel,
  input  logic               auto,
  input  logic               frame_start,
  input  logic               err_clr,
  output logic [4*WIDTH-1:0] y,
  output logic [3:0]         y_valid,
  output logic [1:0]         slot,
  output logic               frame_done,
  output logic               frame_err
`ifdef TDM_DEMUX_FRAME_CNT_EN
  ,
  output logic [7:0]         frame_cnt
`endif
);

  localparam int unsigned NCH = 4;

  typedef enum logic {IDLE, SCAN} state_t;
  state_t state;

  logic       wr;
  logic [1:0] wr_ch;
  logic       err_set;
  logic       last_wr;
  logic       short_frame;

  // Write/error decode; a frame_start coinciding with the slot-3 write is a clean boundary
  always_comb begin
    wr          = 1'b0;
    wr_ch       = 2'd0;
    err_set     = 1'b0;
    last_wr     = 1'b0;
    short_frame = 1'b0;
    if (!auto) begin
      wr    = in_valid;
      wr_ch = sel;
    end else if (state == IDLE) begin
      if (frame_start) wr = in_valid;
      else             err_set = in_valid;
    end else begin
      last_wr = in_valid && (slot == 2'd3);
      if (frame_start && !last_wr) begin
        short_frame = 1'b1;
        err_set     = 1'b1;
        wr          = in_valid;
      end else begin
        wr    = in_valid;
        wr_ch = slot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      slot       <= 2'd0;
      y          <= '0;
      y_valid    <= 4'b0000;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
`ifdef TDM_DEMUX_FRAME_CNT_EN
      frame_cnt  <= 8'd0;
`endif
    end else begin
      // With HOLD=0 a channel shows its word for exactly one cycle unless rewritten
      for (int n = 0; n < NCH; n++) begin
        if (wr && wr_ch == 2'(n))
          y[n*WIDTH +: WIDTH] <= x;
        else if (HOLD == 0 && y_valid[n])
          y[n*WIDTH +: WIDTH] <= '0;
      end
      y_valid    <= wr ? 4'(4'b0001 << wr_ch) : 4'b0000;
      frame_done <= last_wr;
      frame_err  <= err_set | (frame_err & ~err_clr);

      if (!auto) begin
        state <= IDLE;
        slot  <= 2'd0;
      end else if (state == IDLE) begin
        if (frame_start) begin
          state <= SCAN;
          slot  <= in_valid ? 2'd1 : 2'd0;
        end
      end else if (short_frame) begin
        slot <= in_valid ? 2'd1 : 2'd0;
      end else if (in_valid) begin
        slot <= slot + 2'd1;
        if (last_wr && !frame_start) state <= IDLE;
      end

`ifdef TDM_DEMUX_FRAME_CNT_EN
      if (last_wr) frame_cnt <= frame_cnt + 8'd1;
`endif
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: HOLD=1 and HOLD=0 instances driven in parallel, checked against a frame-level model.
module tb_tdm_demux4;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] x = '0;
  logic         in_valid = 1'b0;
  logic [1:0]   sel = 2'd0;
  logic         auto_mode = 1'b0;
  logic         frame_start = 1'b0;
  logic         err_clr = 1'b0;

  logic [4*W-1:0] y_h, y_c;
  logic [3:0]     yv_h, yv_c;
  logic [1:0]     slot_h, slot_c;
  logic           fd_h, fd_c, fe_h, fe_c;
`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [7:0]     fc_h, fc_c;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int n_done = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(W), .HOLD(1)) dut_h (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .sel(sel), .auto(auto_mode),
    .frame_start(frame_start), .err_clr(err_clr), .y(y_h), .y_valid(yv_h), .slot(slot_h),
    .frame_done(fd_h), .frame_err(fe_h)
`ifdef TDM_DEMUX_FRAME_CNT_EN
    , .frame_cnt(fc_h)
`endif
  );

  tdm_demux4 #(.WIDTH(W), .HOLD(0)) dut_c (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .sel(sel), .auto(auto_mode),
    .frame_start(frame_start), .err_clr(err_clr), .y(y_c), .y_valid(yv_c), .slot(slot_c),
    .frame_done(fd_c), .frame_err(fe_c)
`ifdef TDM_DEMUX_FRAME_CNT_EN
    , .frame_cnt(fc_c)
`endif
  );

  // Frame-level model: channel contents, words written in the current frame, error/done/count
  int m_yh[4];
  int m_yc[4];
  int m_vld = -1;
  bit m_frame = 1'b0;
  int m_slot = 0;
  bit m_done = 1'b0;
  bit m_err = 1'b0;
  int m_cnt = 0;

  always @(posedge clk) begin : model
    int wch;
    bit es;
    bit dn;
    bit last;
    wch = -1;
    es = 1'b0;
    dn = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_yh[i] = 0;
        m_yc[i] = 0;
      end
      m_vld = -1; m_frame = 1'b0; m_slot = 0; m_done = 1'b0; m_err = 1'b0; m_cnt = 0;
    end else begin
      if (!auto_mode) begin
        if (in_valid) wch = int'(sel);
        m_frame = 1'b0;
        m_slot = 0;
      end else if (!m_frame) begin
        if (frame_start) begin
          m_frame = 1'b1;
          m_slot = 0;
          if (in_valid) begin
            wch = 0;
            m_slot = 1;
          end
        end else if (in_valid) begin
          es = 1'b1;
        end
      end else begin
        last = in_valid && (m_slot == 3);
        if (frame_start && !last) begin
          es = 1'b1;
          m_slot = 0;
          if (in_valid) begin
            wch = 0;
            m_slot = 1;
          end
        end else if (in_valid) begin
          wch = m_slot;
          m_slot = (m_slot + 1) % 4;
          if (last) begin
            dn = 1'b1;
            if (!frame_start) m_frame = 1'b0;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (i == wch) begin
          m_yh[i] = int'(x);
          m_yc[i] = int'(x);
        end else if (i == m_vld) begin
          m_yc[i] = 0;
        end
      end
      m_vld = wch;
      m_done = dn;
      m_err = es || (m_err && !err_clr);
      if (dn) m_cnt = (m_cnt + 1) % 256;
    end
  end

  function automatic logic [15:0] pack(input bit clr);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'(clr ? m_yc[i] : m_yh[i]);
    return r;
  endfunction

  function automatic logic [3:0] exp_vld();
    return (m_vld >= 0) ? 4'(1 << m_vld) : 4'b0000;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input logic [15:0] dut_v, input logic [15:0] mod_v,
                     input logic [15:0] e);
    chk({nm, "_dut"}, dut_v, e);
    chk({nm, "_model"}, mod_v, e);
  endtask

  // Cycle-by-cycle compare of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("y_hold", 16'(y_h), pack(1'b0));
      chk("y_clr", 16'(y_c), pack(1'b1));
      chk("y_valid_hold", 16'(yv_h), 16'(exp_vld()));
      chk("y_valid_clr", 16'(yv_c), 16'(exp_vld()));
      chk("slot_hold", 16'(slot_h), 16'(m_slot));
      chk("slot_clr", 16'(slot_c), 16'(m_slot));
      chk("frame_done_hold", 16'(fd_h), 16'(m_done));
      chk("frame_done_clr", 16'(fd_c), 16'(m_done));
      chk("frame_err_hold", 16'(fe_h), 16'(m_err));
      chk("frame_err_clr", 16'(fe_c), 16'(m_err));
`ifdef TDM_DEMUX_FRAME_CNT_EN
      chk("frame_cnt_hold", 16'(fc_h), 16'(m_cnt));
      chk("frame_cnt_clr", 16'(fc_c), 16'(m_cnt));
`endif
    end
  end

  task automatic step(input bit r, input bit a, input bit v, input bit fs, input bit ec,
                      input int s, input int xv);
    rst = r; auto_mode = a; in_valid = v; frame_start = fs; err_clr = ec;
    sel = 2'(s); x = 4'(xv);
    @(negedge clk);
    if (fd_h) n_done++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    lit("reset_y", 16'(y_h), pack(1'b0), 16'h0000);
    lit("reset_err", 16'(fe_h), 16'(m_err), 16'h0);

    // Manual mode writes
    step(0, 0, 1, 0, 0, 2, 4'hA);
    lit("man_vld0", 16'(yv_h), 16'(exp_vld()), 16'b0100);
    step(0, 0, 1, 1, 0, 0, 4'h5);
    lit("man_vld1", 16'(yv_h), 16'(exp_vld()), 16'b0001);
    step(0, 0, 1, 0, 0, 3, 4'hF);
    lit("man_vld2", 16'(yv_h), 16'(exp_vld()), 16'b1000);
    lit("man_y", 16'(y_h), pack(1'b0), 16'hFA05);
    lit("man_y_clr", 16'(y_c), pack(1'b1), 16'hF000);
    lit("man_slot", 16'(slot_h), 16'(m_slot), 16'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    lit("idle_y_clr", 16'(y_c), pack(1'b1), 16'h0000);
    step(0, 0, 1, 0, 0, 1, 4'h3);
    step(0, 0, 1, 0, 0, 1, 4'hC);
    lit("rewrite_y_clr", 16'(y_c), pack(1'b1), 16'h00C0);

    // Auto frame with one gap cycle
    step(0, 1, 1, 1, 0, 0, 1);
    lit("auto_slot0", 16'(slot_h), 16'(m_slot), 16'h1);
    step(0, 1, 1, 0, 0, 0, 2);
    lit("auto_slot1", 16'(slot_h), 16'(m_slot), 16'h2);
    step(0, 1, 0, 0, 0, 0, 0);
    lit("auto_gap", 16'(slot_h), 16'(m_slot), 16'h2);
    step(0, 1, 1, 0, 0, 0, 3);
    lit("auto_slot2", 16'(slot_h), 16'(m_slot), 16'h3);
    step(0, 1, 1, 0, 0, 0, 4);
    lit("auto_slot3", 16'(slot_h), 16'(m_slot), 16'h0);
    lit("auto_y", 16'(y_h), pack(1'b0), 16'h4321);
    lit("auto_done", 16'(fd_h), 16'(m_done), 16'h1);
    step(0, 1, 0, 0, 0, 0, 0);
    lit("auto_done_end", 16'(fd_h), 16'(m_done), 16'h0);
    lit("auto_err", 16'(fe_h), 16'(m_err), 16'h0);

    // Short frame, then err_clr
    step(0, 1, 1, 1, 0, 0, 5);
    step(0, 1, 1, 0, 0, 0, 6);
    step(0, 1, 1, 1, 0, 0, 9);
    lit("short_err", 16'(fe_h), 16'(m_err), 16'h1);
    lit("short_slot", 16'(slot_h), 16'(m_slot), 16'h1);
    lit("short_y", 16'(y_h), pack(1'b0), 16'h4369);
    step(0, 1, 0, 0, 1, 0, 0);
    lit("short_clr", 16'(fe_h), 16'(m_err), 16'h0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Orphan data in IDLE, then set-wins-over-clear
    step(0, 1, 1, 0, 0, 0, 7);
    lit("orphan_y", 16'(y_h), pack(1'b0), 16'h4369);
    lit("orphan_vld", 16'(yv_h), 16'(exp_vld()), 16'h0);
    lit("orphan_err", 16'(fe_h), 16'(m_err), 16'h1);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 1, 0, 7);
    lit("set_wins", 16'(fe_h), 16'(m_err), 16'h1);
    step(0, 1, 0, 0, 1, 0, 0);

    // Back-to-back frames with frame_start on the slot-3 write
    step(1, 1, 0, 0, 0, 0, 0);
    n_done = 0;
    for (int i = 0; i < 8; i++) step(0, 1, 1, (i == 0 || i == 3), 0, 0, i + 1);
    lit("b2b_y", 16'(y_h), pack(1'b0), 16'h8765);
    chk("b2b_done_count", 16'(n_done), 16'd2);
    lit("b2b_err", 16'(fe_h), 16'(m_err), 16'h0);
`ifdef TDM_DEMUX_FRAME_CNT_EN
    lit("b2b_cnt", 16'(fc_h), 16'(m_cnt), 16'd2);
`endif

    // Abort by dropping auto mid-frame
    step(0, 1, 1, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 0, 0);
    lit("abort_slot", 16'(slot_h), 16'(m_slot), 16'h0);
    lit("abort_done", 16'(fd_h), 16'(m_done), 16'h0);
    lit("abort_err", 16'(fe_h), 16'(m_err), 16'h0);

    // Reset mid-frame at slot 2 with other inputs active
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 3);
    step(0, 1, 1, 0, 0, 0, 4);
    lit("pre_rst_slot", 16'(slot_h), 16'(m_slot), 16'h2);
    lit("pre_rst_err", 16'(fe_h), 16'(m_err), 16'h1);
`ifdef TDM_DEMUX_FRAME_CNT_EN
    lit("pre_rst_cnt", 16'(fc_h), 16'(m_cnt), 16'd2);
`endif
    step(1, 1, 1, 1, 0, 2, 5);
    lit("rst_y", 16'(y_h), pack(1'b0), 16'h0000);
    lit("rst_vld", 16'(yv_h), 16'(exp_vld()), 16'h0);
    lit("rst_slot", 16'(slot_h), 16'(m_slot), 16'h0);
    lit("rst_done", 16'(fd_h), 16'(m_done), 16'h0);
    lit("rst_err", 16'(fe_h), 16'(m_err), 16'h0);
`ifdef TDM_DEMUX_FRAME_CNT_EN
    lit("rst_cnt", 16'(fc_h), 16'(m_cnt), 16'd0);
`endif
    step(0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
